// File: rtl/decode_stage_p.sv
// Pipelined MIPS decode stage: IF/ID register, write-first register file, forwarding, branch/jump resolution.
// Optional stall/flush performance counters are enabled with `define DECODE_PERF_CNT_EN.
module decode_stage_p #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr_f,
    input  logic [DATA_W-1:0]     pc_plus_4_f,
    input  logic                  valid_f,
    input  logic                  stall_d,
    input  logic                  flush_d,
    input  logic                  reg_we_w,
    input  logic [REG_ADDR_W-1:0] reg_write_addr_w,
    input  logic [DATA_W-1:0]     reg_write_data_w,
    input  logic [DATA_W-1:0]     alu_result_m,
    input  logic [1:0]            forward_a_d,
    input  logic [1:0]            forward_b_d,
    input  logic [2:0]            branch_mode_d,
    output logic                  valid_d,
    output logic [31:0]           instr_d,
    output logic [REG_ADDR_W-1:0] rs_d,
    output logic [REG_ADDR_W-1:0] rt_d,
    output logic [REG_ADDR_W-1:0] rd_d,
    output logic [DATA_W-1:0]     reg_src_a_d,
    output logic [DATA_W-1:0]     reg_src_b_d,
    output logic [DATA_W-1:0]     imm_d,
    output logic [DATA_W-1:0]     shamt_d,
    output logic [DATA_W-1:0]     pc_branch_d,
    output logic [DATA_W-1:0]     pc_jump_d,
`ifdef DECODE_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cnt_d,
    output logic [CNT_W-1:0]      flush_cnt_d,
`endif
    output logic                  branch_taken_d
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    typedef enum logic [2:0] {
        BR_NONE  = 3'b000,
        BR_EQ    = 3'b001,
        BR_NE    = 3'b010,
        BR_LEZ   = 3'b011,
        BR_GTZ   = 3'b100,
        BR_LTZ   = 3'b101,
        BR_GEZ   = 3'b110,
        BR_NONE7 = 3'b111
    } branch_mode_e;

    generate
        if (DATA_W < 32) begin : g_bad_data_w
            $error("decode_stage_p: DATA_W must be >= 32");
        end
        if (CNT_W == 0) begin : g_bad_cnt_w
            $error("decode_stage_p: CNT_W must be >= 1");
        end
    endgenerate

    logic [DATA_W-1:0] pc_plus_4_d;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic              cond;
    logic              a_neg;
    logic              a_zero;
    branch_mode_e      mode;

    // Flush clears the slot but keeps the PC so the bubble still carries a sane address.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d     <= '0;
            pc_plus_4_d <= '0;
            valid_d     <= 1'b0;
        end else if (flush_d) begin
            instr_d <= '0;
            valid_d <= 1'b0;
        end else if (!stall_d) begin
            instr_d     <= instr_f;
            pc_plus_4_d <= pc_plus_4_f;
            valid_d     <= valid_f;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we_w && (reg_write_addr_w != '0)) begin
            regs[reg_write_addr_w] <= reg_write_data_w;
        end
    end

    assign rs_d    = REG_ADDR_W'(instr_d[25:21]);
    assign rt_d    = REG_ADDR_W'(instr_d[20:16]);
    assign rd_d    = REG_ADDR_W'(instr_d[15:11]);
    assign imm_d   = {{(DATA_W-16){instr_d[15]}}, instr_d[15:0]};
    assign shamt_d = {{(DATA_W-5){1'b0}}, instr_d[10:6]};

    // Same-cycle writeback bypass; r0 is never bypassed so it always reads zero.
    always_comb begin
        rf_a = regs[rs_d];
        rf_b = regs[rt_d];
        if (reg_we_w && (reg_write_addr_w != '0) && (reg_write_addr_w == rs_d)) begin
            rf_a = reg_write_data_w;
        end
        if (reg_we_w && (reg_write_addr_w != '0) && (reg_write_addr_w == rt_d)) begin
            rf_b = reg_write_data_w;
        end
    end

    always_comb begin
        reg_src_a_d = rf_a;
        case (forward_a_d)
            2'b01:   reg_src_a_d = alu_result_m;
            2'b10:   reg_src_a_d = reg_write_data_w;
            default: reg_src_a_d = rf_a;
        endcase
    end

    always_comb begin
        reg_src_b_d = rf_b;
        case (forward_b_d)
            2'b01:   reg_src_b_d = alu_result_m;
            2'b10:   reg_src_b_d = reg_write_data_w;
            default: reg_src_b_d = rf_b;
        endcase
    end

    assign a_neg  = reg_src_a_d[DATA_W-1];
    assign a_zero = (reg_src_a_d == '0);
    assign mode   = branch_mode_e'(branch_mode_d);

    always_comb begin
        cond = 1'b0;
        case (mode)
            BR_EQ:   cond = (reg_src_a_d == reg_src_b_d);
            BR_NE:   cond = (reg_src_a_d != reg_src_b_d);
            BR_LEZ:  cond = a_neg | a_zero;
            BR_GTZ:  cond = ~a_neg & ~a_zero;
            BR_LTZ:  cond = a_neg;
            BR_GEZ:  cond = ~a_neg;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken_d = valid_d & cond;
    assign pc_branch_d    = pc_plus_4_d + (imm_d << 2);
    assign pc_jump_d      = {pc_plus_4_d[DATA_W-1:28], instr_d[25:0], 2'b00};

`ifdef DECODE_PERF_CNT_EN
    // A cycle with both stall and flush counts only as a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_d <= '0;
            flush_cnt_d <= '0;
        end else if (flush_d) begin
            if (flush_cnt_d != '1) begin
                flush_cnt_d <= flush_cnt_d + CNT_W'(1);
            end
        end else if (stall_d && (stall_cnt_d != '1)) begin
            stall_cnt_d <= stall_cnt_d + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage_p.sv
// Table-driven bench for decode_stage_p plus hand sequences for stall/flush, reset and perf counters.
module tb_decode_stage_p;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_f;
    logic [31:0] pc_plus_4_f;
    logic        valid_f;
    logic        stall_d;
    logic        flush_d;
    logic        reg_we_w;
    logic [4:0]  reg_write_addr_w;
    logic [31:0] reg_write_data_w;
    logic [31:0] alu_result_m;
    logic [1:0]  forward_a_d;
    logic [1:0]  forward_b_d;
    logic [2:0]  branch_mode_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [4:0]  rs_d;
    logic [4:0]  rt_d;
    logic [4:0]  rd_d;
    logic [31:0] reg_src_a_d;
    logic [31:0] reg_src_b_d;
    logic [31:0] imm_d;
    logic [31:0] shamt_d;
    logic [31:0] pc_branch_d;
    logic [31:0] pc_jump_d;
    logic        branch_taken_d;
`ifdef DECODE_PERF_CNT_EN
    logic [1:0]  stall_cnt_d;
    logic [1:0]  flush_cnt_d;
`endif

    decode_stage_p #(
        .DATA_W(32),
        .REG_ADDR_W(5),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .instr_f(instr_f),
        .pc_plus_4_f(pc_plus_4_f),
        .valid_f(valid_f),
        .stall_d(stall_d),
        .flush_d(flush_d),
        .reg_we_w(reg_we_w),
        .reg_write_addr_w(reg_write_addr_w),
        .reg_write_data_w(reg_write_data_w),
        .alu_result_m(alu_result_m),
        .forward_a_d(forward_a_d),
        .forward_b_d(forward_b_d),
        .branch_mode_d(branch_mode_d),
        .valid_d(valid_d),
        .instr_d(instr_d),
        .rs_d(rs_d),
        .rt_d(rt_d),
        .rd_d(rd_d),
        .reg_src_a_d(reg_src_a_d),
        .reg_src_b_d(reg_src_b_d),
        .imm_d(imm_d),
        .shamt_d(shamt_d),
        .pc_branch_d(pc_branch_d),
        .pc_jump_d(pc_jump_d),
`ifdef DECODE_PERF_CNT_EN
        .stall_cnt_d(stall_cnt_d),
        .flush_cnt_d(flush_cnt_d),
`endif
        .branch_taken_d(branch_taken_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        vf;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [2:0]  bm;
        logic [31:0] alu;
        logic [31:0] wd;
        logic        we;
        logic [4:0]  wa;
        logic [4:0]  e_rs;
        logic [4:0]  e_rt;
        logic [4:0]  e_rd;
        logic [31:0] e_sh;
        logic [31:0] e_imm;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_pcb;
        logic [31:0] e_pcj;
        logic        e_tk;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [31:0] instr, input logic [31:0] pc4, input logic vf,
                               input logic [1:0] fa, input logic [1:0] fb, input logic [2:0] bm,
                               input logic [31:0] alu, input logic [31:0] wd, input logic we,
                               input logic [4:0] wa, input logic [4:0] e_rs, input logic [4:0] e_rt,
                               input logic [4:0] e_rd, input logic [31:0] e_sh, input logic [31:0] e_imm,
                               input logic [31:0] e_a, input logic [31:0] e_b, input logic [31:0] e_pcb,
                               input logic [31:0] e_pcj, input logic e_tk);
        vec_t r;
        r.instr = instr; r.pc4 = pc4; r.vf = vf; r.fa = fa; r.fb = fb; r.bm = bm;
        r.alu = alu; r.wd = wd; r.we = we; r.wa = wa;
        r.e_rs = e_rs; r.e_rt = e_rt; r.e_rd = e_rd; r.e_sh = e_sh; r.e_imm = e_imm;
        r.e_a = e_a; r.e_b = e_b; r.e_pcb = e_pcb; r.e_pcj = e_pcj; r.e_tk = e_tk;
        return r;
    endfunction

    task automatic idle_inputs();
        stall_d = 1'b0; flush_d = 1'b0; reg_we_w = 1'b0; reg_write_addr_w = '0;
        reg_write_data_w = '0; alu_result_m = '0; forward_a_d = '0; forward_b_d = '0;
        branch_mode_d = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; instr_f = '0; pc_plus_4_f = '0; valid_f = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_we_w = 1'b1; reg_write_addr_w = a; reg_write_data_w = d;
        @(posedge clk);
        #1 reg_we_w = 1'b0; reg_write_data_w = '0;
    endtask

    task automatic run_row(input int idx, input vec_t t);
        instr_f = t.instr; pc_plus_4_f = t.pc4; valid_f = t.vf;
        idle_inputs();
        @(posedge clk);
        #1;
        forward_a_d = t.fa; forward_b_d = t.fb; branch_mode_d = t.bm;
        alu_result_m = t.alu; reg_write_data_w = t.wd; reg_we_w = t.we; reg_write_addr_w = t.wa;
        #1;
        chk($sformatf("row%0d valid_d", idx), 32'(valid_d), 32'(t.vf));
        chk($sformatf("row%0d instr_d", idx), instr_d, t.instr);
        chk($sformatf("row%0d rs_d", idx), 32'(rs_d), 32'(t.e_rs));
        chk($sformatf("row%0d rt_d", idx), 32'(rt_d), 32'(t.e_rt));
        chk($sformatf("row%0d rd_d", idx), 32'(rd_d), 32'(t.e_rd));
        chk($sformatf("row%0d shamt_d", idx), shamt_d, t.e_sh);
        chk($sformatf("row%0d imm_d", idx), imm_d, t.e_imm);
        chk($sformatf("row%0d src_a", idx), reg_src_a_d, t.e_a);
        chk($sformatf("row%0d src_b", idx), reg_src_b_d, t.e_b);
        chk($sformatf("row%0d pc_branch", idx), pc_branch_d, t.e_pcb);
        chk($sformatf("row%0d pc_jump", idx), pc_jump_d, t.e_pcj);
        chk($sformatf("row%0d taken", idx), 32'(branch_taken_d), 32'(t.e_tk));
        reg_we_w = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        // I0: rs=1 rt=2 imm=4 | I1: rs=3 rt=0 imm=FFFC | I2: jump | I3: rs=5 | I4: rs=rt=0 | I5: R-type rs=4 rt=6 rd=7 sh=3
        vecs.push_back(v(32'h8C220004, 32'h00001000, 1, 0, 0, 3'b001, 0, 0, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 1));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 1, 0, 0, 3'b010, 0, 0, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 0));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 1, 0, 0, 3'b101, 0, 0, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 1));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 1, 0, 0, 3'b100, 0, 0, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 0));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 1, 0, 0, 3'b110, 0, 0, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 0));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 1, 0, 0, 3'b011, 0, 0, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 1));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 1, 0, 0, 3'b000, 0, 0, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 0));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 1, 0, 0, 3'b111, 0, 0, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 0));
        vecs.push_back(v(32'h1060FFFC, 32'h00400010, 1, 0, 0, 3'b011, 0, 0, 0, 0, 3, 0, 31, 31, 32'hFFFFFFFC, 0, 0, 32'h00400000, 32'h0183FFF0, 1));
        vecs.push_back(v(32'h1060FFFC, 32'h00400010, 1, 0, 0, 3'b110, 0, 0, 0, 0, 3, 0, 31, 31, 32'hFFFFFFFC, 0, 0, 32'h00400000, 32'h0183FFF0, 1));
        vecs.push_back(v(32'h1060FFFC, 32'h00400010, 1, 0, 0, 3'b101, 0, 0, 0, 0, 3, 0, 31, 31, 32'hFFFFFFFC, 0, 0, 32'h00400000, 32'h0183FFF0, 0));
        vecs.push_back(v(32'h1060FFFC, 32'h00400010, 1, 0, 0, 3'b100, 0, 0, 0, 0, 3, 0, 31, 31, 32'hFFFFFFFC, 0, 0, 32'h00400000, 32'h0183FFF0, 0));
        vecs.push_back(v(32'h08100004, 32'h90000000, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 16, 0, 0, 32'h4, 0, 0, 32'h90000010, 32'h90400010, 0));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 1, 1, 2, 3'b010, 32'h11, 32'h22, 0, 0, 1, 2, 0, 0, 32'h4, 32'h11, 32'h22, 32'h00001010, 32'h00880010, 1));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 1, 3, 3, 3'b001, 32'h11, 32'h22, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 1));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 0, 0, 0, 3'b001, 0, 0, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 0));
        vecs.push_back(v(32'h8C220004, 32'h00001000, 0, 0, 0, 3'b011, 0, 0, 0, 0, 1, 2, 0, 0, 32'h4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00001010, 32'h00880010, 0));
        vecs.push_back(v(32'h10A00000, 32'h00002000, 1, 0, 0, 3'b101, 0, 32'hDEADBEEF, 1, 5, 5, 0, 0, 0, 32'h0, 32'hDEADBEEF, 0, 32'h00002000, 32'h02800000, 1));
        vecs.push_back(v(32'h10000000, 32'h00003000, 1, 0, 0, 3'b001, 0, 32'h12345678, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h00003000, 32'h00000000, 1));
        vecs.push_back(v(32'h10000000, 32'h00003000, 1, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h00003000, 32'h00000000, 1));
        vecs.push_back(v(32'h008638C0, 32'h00004000, 1, 0, 0, 3'b100, 0, 0, 0, 0, 4, 6, 7, 3, 32'h38C0, 32'h7, 32'h80000000, 32'h00012300, 32'h0218E300, 1));
        vecs.push_back(v(32'h008638C0, 32'h00004000, 1, 0, 0, 3'b010, 0, 0, 0, 0, 4, 6, 7, 3, 32'h38C0, 32'h7, 32'h80000000, 32'h00012300, 32'h0218E300, 1));

        do_reset();
        chk("reset valid_d", 32'(valid_d), 32'h0);
        chk("reset instr_d", instr_d, 32'h0);
        chk("reset imm_d", imm_d, 32'h0);
        chk("reset src_a", reg_src_a_d, 32'h0);
        chk("reset pc_branch", pc_branch_d, 32'h0);
        chk("reset pc_jump", pc_jump_d, 32'h0);
        chk("reset taken", 32'(branch_taken_d), 32'h0);

        wr(5'd1, 32'hFFFFFFFF);
        wr(5'd2, 32'hFFFFFFFF);
        wr(5'd4, 32'h00000007);
        wr(5'd6, 32'h80000000);
        wr(5'd0, 32'hABCD1234);

        foreach (vecs[i]) run_row(i, vecs[i]);

        // Stall holds IF/ID for three cycles, then a flush during stall inserts a bubble but keeps the PC.
        instr_f = 32'h8C220004; pc_plus_4_f = 32'h00001000; valid_f = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1 stall_d = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr_f = 32'h1000_0000 + 32'(k); pc_plus_4_f = 32'h0000_5000 + 32'(k * 4);
            @(posedge clk);
            #1;
            chk($sformatf("stall%0d instr_d", k), instr_d, 32'h8C220004);
            chk($sformatf("stall%0d pc_branch", k), pc_branch_d, 32'h00001010);
            chk($sformatf("stall%0d valid_d", k), 32'(valid_d), 32'h1);
        end
        flush_d = 1'b1; instr_f = 32'h008638C0; pc_plus_4_f = 32'h00007000;
        @(posedge clk);
        #1;
        chk("flush valid_d", 32'(valid_d), 32'h0);
        chk("flush instr_d", instr_d, 32'h0);
        chk("flush pc kept", pc_branch_d, 32'h00001000);
        branch_mode_d = 3'b011;
        #1 chk("flush taken", 32'(branch_taken_d), 32'h0);
        stall_d = 1'b0; flush_d = 1'b0;
        @(posedge clk);
        #1 chk("after flush load", instr_d, 32'h008638C0);

`ifdef DECODE_PERF_CNT_EN
        do_reset();
        chk("reset stall_cnt", 32'(stall_cnt_d), 32'h0);
        chk("reset flush_cnt", 32'(flush_cnt_d), 32'h0);
        stall_d = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("stall_cnt saturate", 32'(stall_cnt_d), 32'h3);
        chk("flush_cnt idle", 32'(flush_cnt_d), 32'h0);
        flush_d = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_cnt one", 32'(flush_cnt_d), 32'h1);
        chk("stall_cnt during flush", 32'(stall_cnt_d), 32'h3);
        stall_d = 1'b0; flush_d = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
Parametrised successor to the MIPS pipeline decode stage. It adds:
- an internal IF/ID pipeline register with stall, flush and valid;
- a write-first register file;
- 3-way operand forwarding from M and W;
- a multi-mode branch comparator;
- jump-target generation.

It sits between fetch and the ID/EX register. It drives the early-branch resolution back to fetch.

Parameters:
DATA_W, 32, datapath width; must be >= 32.
REG_ADDR_W, 5, register address width; register file holds 2**REG_ADDR_W entries.
CNT_W, 32, width of the performance counters; used only with DECODE_PERF_CNT_EN.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
instr_f  in  32  fetched instruction.
pc_plus_4_f  in  DATA_W  fetch PC+4.
valid_f  in  1  fetch slot holds a real instruction.
stall_d  in  1  hold the IF/ID register.
flush_d  in  1  load a bubble into IF/ID.
reg_we_w  in  1  writeback enable.
reg_write_addr_w  in  REG_ADDR_W  writeback address.
reg_write_data_w  in  DATA_W  writeback data.
alu_result_m  in  DATA_W  memory-stage ALU result, used for forwarding.
forward_a_d  in  2  rs source select: 00 regfile, 01 alu_result_m, 10 reg_write_data_w, 11 regfile.
forward_b_d  in  2  rt source select; same encoding.
branch_mode_d  in  3  000 none, 001 eq, 010 ne, 011 lez, 100 gtz, 101 ltz, 110 gez, 111 none.
valid_d  out  1  IF/ID slot valid.
instr_d  out  32  latched instruction.
rs_d / rt_d / rd_d  out  REG_ADDR_W each  instr_d[25:21], [20:16], [15:11], zero-extended or truncated to REG_ADDR_W.
reg_src_a_d / reg_src_b_d  out  DATA_W each  forwarded operands.
imm_d  out  DATA_W  sign-extended instr_d[15:0].
shamt_d  out  DATA_W  zero-extended instr_d[10:6].
pc_branch_d  out  DATA_W  branch target.
pc_jump_d  out  DATA_W  jump target.
branch_taken_d  out  1  branch resolves taken.

Behaviour:
IF/ID register, priority reset > flush > stall > load:
- reset: instr_d=0, pc_plus_4_d=0, valid_d=0.
- flush (regardless of stall_d): instr_d=0, valid_d=0; pc_plus_4_d keeps its value.
- stall: all IF/ID fields hold.
- otherwise: load instr_f, pc_plus_4_f and valid_f.

Register file:
- Register 0 reads 0 and ignores writes.
- On reset, all entries clear to 0.
- Writes take effect at the rising edge when reg_we_w=1.
- Reads are combinational and write-first. If reg_we_w=1, reg_write_addr_w equals the read address and that address is non-zero, the read returns reg_write_data_w in the same cycle.
- reset and write in the same cycle: reset wins.

Forwarding:
- Pure combinational mux per the select encoding.
- Select 11 behaves as 00.

Branch compare, signed on reg_src_a_d/reg_src_b_d:
- eq: a==b.
- ne: a!=b.
- lez: a<=0.
- gtz: a>0.
- ltz: a<0.
- gez: a>=0.
- branch_taken_d = valid_d AND condition. It is 0 for modes 000 and 111, and 0 whenever valid_d=0.

Target generation:
- pc_branch_d = pc_plus_4_d + (imm_d << 2), modulo 2**DATA_W.
- pc_jump_d = {pc_plus_4_d[DATA_W-1:28], instr_d[25:0], 2'b00}.

Latency and reset values:
- All decode outputs are combinational from IF/ID state plus the W/M inputs, so an instruction is presented 1 cycle after fetch.
- After reset every output is 0 (instr_d=0 decodes to all-zero fields) as long as the forwarding inputs are 0.

Optional Feature:
Macro DECODE_PERF_CNT_EN.

When defined:
- Adds outputs stall_cnt_d [CNT_W] and flush_cnt_d [CNT_W]; both are cleared by reset.
- stall_cnt_d increments on each cycle with stall_d=1 and flush_d=0.
- flush_cnt_d increments on each cycle with flush_d=1.
- Both counters saturate at all-ones and do not wrap.

When undefined:
- The ports and logic are absent.
- All other behaviour is identical.

Test Plan:
- Reset, then load instr_f=0x8C220004, valid_f=1: after 1 cycle, instr_d=0x8C220004, rs_d=1, rt_d=2, imm_d=4, valid_d=1.
- stall_d=1 for 3 cycles while instr_f changes: instr_d holds. Then assert stall_d=1 together with flush_d=1: result is valid_d=0, instr_d=0.
- Write 0xDEADBEEF to r5 with reg_we_w=1 while the decoded instruction reads rs=5: reg_src_a_d=0xDEADBEEF in the same cycle. A write to r0 leaves r0 reading 0.
- forward_a_d=01 with alu_result_m=0x11: reg_src_a_d=0x11. forward_b_d=10 with reg_write_data_w=0x22: reg_src_b_d=0x22. forward_b_d=11 selects the regfile value.
- Branch modes, with a=0xFFFFFFFF and b=0xFFFFFFFF:
  - eq gives taken=1; ne gives 0; ltz gives 1; gtz gives 0; gez gives 0; lez gives 1.
  - With a=0: lez gives 1, gez gives 1, ltz gives 0.
  - With valid_d=0 every mode gives taken=0.
- Target wrap: pc_plus_4_d=0x00400010 with imm=0xFFFC gives pc_branch_d=0x00400000. instr 0x08100004 with pc_plus_4_d=0x90000000 gives pc_jump_d=0x90400010. With DECODE_PERF_CNT_EN and CNT_W=2, 5 stall cycles give stall_cnt_d=3.
